mem_stage_hs: RTL
=================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter DW, default 32: data width; legal values are 32 and 64.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter TMO, default 16: cycles allowed in REQ+RSP before a bus fault is raised.
REQ-004 clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 valid_i  in  1: the pipeline presents an instruction this cycle.
REQ-007 load_i / store_i  in  1 each: the instruction is a load / a store.
REQ-008 funct3_i  in  3: access size and sign (RV LB/LH/LW/LBU/LHU, SB/SH/SW, plus LD/LWU/SD when DW=64).
REQ-009 addr_i  in  AW: effective address (ALU result).
REQ-010 wdata_i  in  DW: store source register value.
REQ-011 stall_o  out  1: hold the pipeline.
REQ-012 done_o  out  1: one-cycle pulse marking access completion.
REQ-013 rdata_o  out  DW: the load result, sign- or zero-extended.
REQ-014 misalign_o  out  1: misaligned access flag.
REQ-015 fault_o  out  1: bus timeout flag.
REQ-016 mem_req_o, mem_we_o  out  1 each: bus request; write enable.
REQ-017 mem_addr_o  out  AW: bus address, aligned to DW/8 bytes.
REQ-018 mem_wdata_o  out  DW: store data replicated into the addressed lanes.
REQ-019 mem_mask_o  out  DW/8: byte-lane enables.
REQ-020 mem_gnt_i, mem_rvalid_i  in  1 each: bus grant; response valid.
REQ-021 mem_rdata_i  in  DW: bus read data.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and RSP.
REQ-023 In IDLE, an access is accepted when valid_i & (load_i | store_i) & aligned; on acceptance, addr/funct3/data/kind are registered, next state is REQ, and stall_o=1 that cycle.
REQ-024 If load_i and store_i are both high, the access SHALL be treated as a store.
REQ-025 Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0. Byte accesses are always aligned.
REQ-026 A misaligned access SHALL assert misalign_o combinationally in the same IDLE cycle, issue no bus request, and keep stall_o=0.
REQ-027 In REQ, mem_req_o=1 with stable address, we, wdata and mask; on mem_gnt_i the FSM moves to RSP; otherwise it stays in REQ.
REQ-028 In RSP, on mem_rvalid_i, done_o pulses the next cycle and the FSM returns to IDLE; stores also wait for rvalid.
REQ-029 stall_o=1 in REQ and RSP; it is 0 in the done_o cycle.
REQ-030 rdata_o is registered and updates only with done_o for loads, extracting lane addr[log2(DW/8)-1:0] and extending per funct3; it holds its value otherwise.
REQ-031 The mask SHALL be: byte = 1<<off; half = 3<<off; word = 0xF<<off; dword = all ones.
REQ-032 The wait counter resets on entering REQ and increments every REQ/RSP cycle; when it reaches TMO-1 without completion, fault_o pulses for one cycle, stall_o drops, and the FSM returns to IDLE with no done_o.
REQ-033 A late mem_rvalid_i arriving in IDLE SHALL be ignored.
REQ-034 Minimum latency: accept at cycle 0, gnt at cycle 1, rvalid at cycle 2, done_o at cycle 3.

Reset
REQ-035 On rst=1 at a clock edge, the FSM enters IDLE, the counter clears, and done_o, fault_o, mem_req_o, mem_we_o, mem_mask_o and rdata_o are 0.
REQ-036 Reset mid-access SHALL abandon the access with no done_o or fault_o pulse.

Structure
REQ-037 The state encoding, funct3 size constants and DW-derived lane-count constants SHALL live in the shared package mem_pkg.
REQ-038 Lane alignment, masking and extension SHALL be one combinational sub-module, mem_align.

Verification
REQ-039 LW at 0x100, gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF -> done_o at cycle 3, rdata_o=0xDEADBEEF, stall_o high for cycles 0-2.
REQ-040 LB at 0x103, rdata 0x80FFFFFF -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-041 SH at 0x202 with wdata 0x1234 -> mem_mask_o=4'b1100, mem_wdata_o=0x12341234, mem_we_o=1.
REQ-042 LW at 0x101 -> misalign_o=1 the same cycle, mem_req_o never asserted, stall_o=0.
REQ-043 Grant withheld with TMO=16 -> fault_o pulses 15 cycles after REQ entry, FSM returns to IDLE, no done_o.
REQ-044 DW=64: LD at 0x8 -> mask 0xFF; rst asserted during RSP -> mem_req_o=0, FSM in IDLE, no done_o.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory stage: FSM encoding, access-size codes
// and helpers that derive lane geometry from the data width.
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // funct3[1:0] encodes the access size; funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: alignment check, byte-enable mask, store-data
// replication and load-data extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
#(
    parameter  int DW = 32,
    localparam int NL = lanes(DW),
    localparam int LB = lane_bits(DW)
) (
    input  logic [2:0]    funct3,
    input  logic [2:0]    addr_lo,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic          aligned,
    output logic [NL-1:0] mask,
    output logic [DW-1:0] wdata_rep,
    output logic [DW-1:0] ldata
);

    logic [LB-1:0] off;
    logic [DW-1:0] rep_b;
    logic [DW-1:0] rep_h;
    logic [DW-1:0] rep_w;
    logic [DW-1:0] shifted;

    assign off     = addr_lo[LB-1:0];
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        case (funct3[1:0])
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~addr_lo[0];
            SZ_W:    aligned = (addr_lo[1:0] == 2'b00);
            default: aligned = (addr_lo == 3'b000);
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            SZ_B:    mask = NL'(1) << off;
            SZ_H:    mask = NL'(3) << off;
            SZ_W:    mask = NL'(15) << off;
            default: mask = '1;
        endcase
    end

    for (genvar gi = 0; gi < NL; gi++) begin : g_rep_b
        assign rep_b[gi*8 +: 8] = wdata[7:0];
    end
    for (genvar gi = 0; gi < NL / 2; gi++) begin : g_rep_h
        assign rep_h[gi*16 +: 16] = wdata[15:0];
    end
    for (genvar gi = 0; gi < DW / 32; gi++) begin : g_rep_w
        assign rep_w[gi*32 +: 32] = wdata[31:0];
    end

    always_comb begin
        case (funct3[1:0])
            SZ_B:    wdata_rep = rep_b;
            SZ_H:    wdata_rep = rep_h;
            SZ_W:    wdata_rep = rep_w;
            default: wdata_rep = wdata;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_LB:   ldata = DW'($signed(shifted[7:0]));
            F3_LH:   ldata = DW'($signed(shifted[15:0]));
            F3_LW:   ldata = DW'($signed(shifted[31:0]));
            F3_LBU:  ldata = DW'(shifted[7:0]);
            F3_LHU:  ldata = DW'(shifted[15:0]);
            F3_LWU:  ldata = DW'(shifted[31:0]);
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage: accepts one load/store, runs a req/gnt then rvalid
// bus handshake with a timeout, and returns the extended load result.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int TMO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DW-1:0]     rdata_o,
    output logic              misalign_o,
    output logic              fault_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_mask_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int NL = lanes(DW);
    localparam int LB = lane_bits(DW);
    localparam int CW = $clog2(TMO + 1);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg;
    logic [2:0]    funct3_reg;
    logic [DW-1:0] wdata_reg;
    logic          store_reg;
    logic          done_reg, done_next;
    logic          fault_reg, fault_next;
    logic [DW-1:0] rdata_reg;

    logic          idle;
    logic          open;
    logic          is_mem;
    logic          accept;
    logic          timeout;
    logic [2:0]    sel_funct3;
    logic [2:0]    sel_addr_lo;
    logic          aligned;
    logic [NL-1:0] mask;
    logic [DW-1:0] wdata_rep;
    logic [DW-1:0] ldata;

    assign idle    = (state_reg == ST_IDLE);
    // The completing (or faulting) instruction is still presented during the
    // pulse cycle, so it must not be accepted a second time.
    assign open    = idle & ~done_reg & ~fault_reg;
    assign is_mem  = valid_i & (load_i | store_i);
    assign accept  = open & is_mem & aligned;
    assign timeout = (cnt_reg == CW'(TMO - 2));

    assign sel_funct3  = idle ? funct3_i    : funct3_reg;
    assign sel_addr_lo = idle ? addr_i[2:0] : addr_reg[2:0];

    mem_align #(.DW(DW)) u_align (
        .funct3    (sel_funct3),
        .addr_lo   (sel_addr_lo),
        .wdata     (wdata_reg),
        .rdata     (mem_rdata_i),
        .aligned   (aligned),
        .mask      (mask),
        .wdata_rep (wdata_rep),
        .ldata     (ldata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        fault_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_REQ;
                    cnt_next   = '0;
                end
            end
            ST_REQ: begin
                cnt_next = cnt_reg + CW'(1);
                if (timeout) begin
                    state_next = ST_IDLE;
                    fault_next = 1'b1;
                end else if (mem_gnt_i) begin
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                cnt_next = cnt_reg + CW'(1);
                if (mem_rvalid_i) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (timeout) begin
                    state_next = ST_IDLE;
                    fault_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            funct3_reg <= '0;
            wdata_reg  <= '0;
            store_reg  <= 1'b0;
            done_reg   <= 1'b0;
            fault_reg  <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            fault_reg <= fault_next;
            if (accept) begin
                addr_reg   <= addr_i;
                funct3_reg <= funct3_i;
                wdata_reg  <= wdata_i;
                store_reg  <= store_i;
            end
            if (done_next && !store_reg) begin
                rdata_reg <= ldata;
            end
        end
    end

    assign stall_o     = accept | ~idle;
    assign misalign_o  = open & is_mem & ~aligned;
    assign done_o      = done_reg;
    assign fault_o     = fault_reg;
    assign rdata_o     = rdata_reg;
    assign mem_req_o   = (state_reg == ST_REQ);
    assign mem_we_o    = mem_req_o & store_reg;
    assign mem_mask_o  = mem_req_o ? mask : '0;
    assign mem_addr_o  = {addr_reg[AW-1:LB], {LB{1'b0}}};
    assign mem_wdata_o = wdata_rep;

endmodule
